// File: rtl/axi_arb_pkg.sv
// Shared arbiter types and the round-robin pick function.
package axi_arb_pkg;

  typedef enum logic {W_IDLE = 1'b0, W_BUSY = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rd_state_e;

  localparam int unsigned MAX_MST = 32;
  localparam int unsigned MAX_IW  = $clog2(MAX_MST);

  // First set bit of req_vec at or after ptr, wrapping modulo num.
  // Returns ptr when nothing is requesting; callers qualify with |req_vec.
  function automatic int unsigned rr_pick(input logic [MAX_MST-1:0] req_vec,
                                          input int unsigned ptr,
                                          input int unsigned num);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_MST; i++) begin
      idx = (ptr + i) % num;
      if (i < num && !found && req_vec[idx[MAX_IW-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axi_default_param_pkg.sv
// Default AXI4-Lite channel and bundle types used by the arbiter.
// axi4l_req_t carries the master-driven signals, axi4l_resp_t the slave-driven ones.
package axi_default_param_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi4l_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axi4l_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi4l_b_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axi4l_r_t;

  typedef struct packed {
    axi4l_ax_t aw;
    logic      aw_valid;
    axi4l_w_t  w;
    logic      w_valid;
    logic      b_ready;
    axi4l_ax_t ar;
    logic      ar_valid;
    logic      r_ready;
  } axi4l_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    axi4l_b_t b;
    logic     b_valid;
    logic     ar_ready;
    axi4l_r_t r;
    logic     r_valid;
  } axi4l_resp_t;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin picker.
// Ports: req_i request vector, ptr_i priority pointer; gnt_o any request,
// idx_o index of the winner (valid when gnt_o).
module axi_rr_arbiter import axi_arb_pkg::*; #(
  parameter  int unsigned NUM = 2,
  localparam int unsigned IW  = $clog2(NUM)
) (
  input  logic [NUM-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic           gnt_o,
  output logic [IW-1:0]  idx_o
);
  logic [MAX_MST-1:0] req_ext;

  always_comb begin
    req_ext          = '0;
    req_ext[NUM-1:0] = req_i;
    idx_o            = IW'(rr_pick(req_ext, 32'(ptr_i), NUM));
  end

  assign gnt_o = |req_i;

endmodule

// File: rtl/fifo.sv
// Small synchronous FIFO with asynchronous active-low reset.
// Ports: clk_i, arst_ni; push_i/data_i write side; pop_i/data_o read side
// (data_o shows the head); full_o/empty_o status. Push while full is accepted
// only together with a pop, keeping occupancy unchanged.
module fifo #(
  parameter int unsigned ELEM_WIDTH = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  push_i,
  input  logic [ELEM_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [ELEM_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ELEM_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/axi_arbiter.sv
// NUM_MST-to-1 AXI4-Lite arbiter. Write (AW+W) and read (AR) paths are granted
// independently, round-robin; B and R are steered back in issue order using
// per-path queues of master indices.
// Ports: clk_i, rst_i (sync, active high); req_i/resp_o upstream masters;
// req_o/resp_i downstream slave.
//
// state  | meaning
// W_IDLE | no write granted; pick a winner when AW pending and B queue has room
// W_BUSY | forwarding winner's AW and W until both have handshaken
// R_IDLE | no read granted; pick a winner when AR pending and R queue has room
// R_BUSY | forwarding winner's AR until it handshakes
module axi_arbiter import axi_arb_pkg::*; #(
  parameter type         axi_req_t   = axi_default_param_pkg::axi4l_req_t,
  parameter type         axi_resp_t  = axi_default_param_pkg::axi4l_resp_t,
  parameter int unsigned NUM_MST     = 2,
  parameter int unsigned B_ORD_DEPTH = 4,
  parameter int unsigned R_ORD_DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  req_i  [NUM_MST],
  output axi_resp_t resp_o [NUM_MST],
  output axi_req_t  req_o,
  input  axi_resp_t resp_i
);
  localparam int unsigned IW = $clog2(NUM_MST);
  typedef logic [IW-1:0] idx_t;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  idx_t      wr_win_q, wr_win_d, wr_ptr_q, wr_ptr_d;
  idx_t      rd_win_q, rd_win_d, rd_ptr_q, rd_ptr_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [NUM_MST-1:0] aw_req, ar_req;
  logic               wr_gnt, rd_gnt;
  idx_t               wr_idx, rd_idx;
  logic               aw_fwd, w_fwd, ar_fwd, aw_hs, w_hs, ar_hs;
  logic               b_pop, b_full, b_empty, r_pop, r_full, r_empty;
  idx_t               b_head, r_head;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NUM_MST - 1)) ? '0 : i + 1'b1;
  endfunction

  for (genvar k = 0; k < NUM_MST; k++) begin : g_req
    assign aw_req[k] = req_i[k].aw_valid;
    assign ar_req[k] = req_i[k].ar_valid;
  end

  axi_rr_arbiter #(.NUM(NUM_MST)) u_wr_arb (
    .req_i(aw_req), .ptr_i(wr_ptr_q), .gnt_o(wr_gnt), .idx_o(wr_idx)
  );

  axi_rr_arbiter #(.NUM(NUM_MST)) u_rd_arb (
    .req_i(ar_req), .ptr_i(rd_ptr_q), .gnt_o(rd_gnt), .idx_o(rd_idx)
  );

  always_comb begin
    req_o      = '0;
    resp_o     = '{default: '0};
    wr_state_d = wr_state_q;
    wr_win_d   = wr_win_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rd_state_d = rd_state_q;
    rd_win_d   = rd_win_q;
    rd_ptr_d   = rd_ptr_q;
    aw_fwd     = 1'b0;
    w_fwd      = 1'b0;
    ar_fwd     = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    ar_hs      = 1'b0;
    b_pop      = 1'b0;
    r_pop      = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        // Full only blocks new grants; a write in flight always gets its push.
        if (wr_gnt && !b_full) begin
          wr_win_d   = wr_idx;
          wr_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        aw_fwd                    = req_i[wr_win_q].aw_valid && !aw_done_q;
        w_fwd                     = req_i[wr_win_q].w_valid && !w_done_q;
        req_o.aw                  = req_i[wr_win_q].aw;
        req_o.aw_valid            = aw_fwd;
        req_o.w                   = req_i[wr_win_q].w;
        req_o.w_valid             = w_fwd;
        resp_o[wr_win_q].aw_ready = resp_i.aw_ready && !aw_done_q;
        resp_o[wr_win_q].w_ready  = resp_i.w_ready && !w_done_q;
        aw_hs                     = aw_fwd && resp_i.aw_ready;
        w_hs                      = w_fwd && resp_i.w_ready;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          wr_state_d = W_IDLE;
          wr_ptr_d   = next_idx(wr_win_q);
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
    endcase

    case (rd_state_q)
      R_IDLE: begin
        if (rd_gnt && !r_full) begin
          rd_win_d   = rd_idx;
          rd_state_d = R_BUSY;
        end
      end
      R_BUSY: begin
        ar_fwd                    = req_i[rd_win_q].ar_valid;
        req_o.ar                  = req_i[rd_win_q].ar;
        req_o.ar_valid            = ar_fwd;
        resp_o[rd_win_q].ar_ready = resp_i.ar_ready;
        ar_hs                     = ar_fwd && resp_i.ar_ready;
        if (ar_hs) begin
          rd_state_d = R_IDLE;
          rd_ptr_d   = next_idx(rd_win_q);
        end
      end
    endcase

    if (!b_empty) begin
      resp_o[b_head].b       = resp_i.b;
      resp_o[b_head].b_valid = resp_i.b_valid;
      req_o.b_ready          = req_i[b_head].b_ready;
      b_pop                  = resp_i.b_valid && req_i[b_head].b_ready;
    end

    if (!r_empty) begin
      resp_o[r_head].r       = resp_i.r;
      resp_o[r_head].r_valid = resp_i.r_valid;
      req_o.r_ready          = req_i[r_head].r_ready;
      r_pop                  = resp_i.r_valid && req_i[r_head].r_ready;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      wr_win_q   <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_win_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_win_q   <= wr_win_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rd_state_q <= rd_state_d;
      rd_win_q   <= rd_win_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  fifo #(.ELEM_WIDTH(IW), .DEPTH(B_ORD_DEPTH)) u_b_ord (
    .clk_i(clk_i), .arst_ni(~rst_i),
    .push_i(aw_hs), .data_i(wr_win_q),
    .pop_i(b_pop), .data_o(b_head),
    .full_o(b_full), .empty_o(b_empty)
  );

  fifo #(.ELEM_WIDTH(IW), .DEPTH(R_ORD_DEPTH)) u_r_ord (
    .clk_i(clk_i), .arst_ni(~rst_i),
    .push_i(ar_hs), .data_i(rd_win_q),
    .pop_i(r_pop), .data_o(r_head),
    .full_o(r_full), .empty_o(r_empty)
  );

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter with two masters and a 2-deep write order queue.
module tb_axi_arbiter;
  import axi_default_param_pkg::*;
  import axi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  axi4l_req_t  req  [2];
  axi4l_resp_t resp [2];
  axi4l_req_t  dreq;
  axi4l_resp_t dresp;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  axi_arbiter #(.NUM_MST(2), .B_ORD_DEPTH(2), .R_ORD_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .resp_o(resp), .req_o(dreq), .resp_i(dresp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req[0] = '0;
    req[1] = '0;
    dresp  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req[k].aw_valid = 1'b1; req[k].w_valid = 1'b1; req[k].ar_valid = 1'b1;
      req[k].b_ready = 1'b1;  req[k].r_ready = 1'b1;
      req[k].aw.addr = 32'h1000 + 32'(k); req[k].ar.addr = 32'h2000 + 32'(k);
    end
    dresp.aw_ready = 1'b1; dresp.w_ready = 1'b1; dresp.ar_ready = 1'b1;
    dresp.b_valid = 1'b1;  dresp.r_valid = 1'b1;
    rst = 1'b1;
    tick();
    checks++; if ({dreq.aw_valid, dreq.w_valid, dreq.ar_valid, dreq.b_ready, dreq.r_ready} !== 5'b0) begin failures++; $display("FAIL rst_down_valids got=%b exp=00000", {dreq.aw_valid, dreq.w_valid, dreq.ar_valid, dreq.b_ready, dreq.r_ready}); end
    checks++; if (dreq.aw.addr !== 32'h0) begin failures++; $display("FAIL rst_down_payload got=%h exp=0", dreq.aw.addr); end
    for (int k = 0; k < 2; k++) begin
      checks++; if ({resp[k].aw_ready, resp[k].w_ready, resp[k].ar_ready, resp[k].b_valid, resp[k].r_valid} !== 5'b0) begin failures++; $display("FAIL rst_up_m%0d got=%b exp=00000", k, {resp[k].aw_ready, resp[k].w_ready, resp[k].ar_ready, resp[k].b_valid, resp[k].r_valid}); end
    end
    checks++; if (dut.wr_state_q !== W_IDLE || dut.rd_state_q !== R_IDLE) begin failures++; $display("FAIL rst_fsm_idle got=%b%b exp=00", dut.wr_state_q, dut.rd_state_q); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (dreq.aw_valid !== 1'b0 || dreq.ar_valid !== 1'b0) begin failures++; $display("FAIL rst_no_early_grant got=%b%b exp=00", dreq.aw_valid, dreq.ar_valid); end
    checks++; if (dut.wr_state_q !== W_IDLE || dut.rd_state_q !== R_IDLE) begin failures++; $display("FAIL rst_release_idle got=%b%b exp=00", dut.wr_state_q, dut.rd_state_q); end
    tick();
    checks++; if (dreq.aw_valid !== 1'b1 || dreq.aw.addr !== 32'h1000) begin failures++; $display("FAIL rst_first_grant got=%b/%h exp=1/00001000", dreq.aw_valid, dreq.aw.addr); end
    checks++; if (dreq.ar_valid !== 1'b1 || dreq.ar.addr !== 32'h2000) begin failures++; $display("FAIL rst_first_rd_grant got=%b/%h exp=1/00002000", dreq.ar_valid, dreq.ar.addr); end
  endtask

  task automatic test_round_robin();
    logic [31:0] sq[$];
    logic [31:0] aw_log[$];
    logic [31:0] exp_aw [3];
    logic [1:0]  exp_resp;
    int          exp_m;
    int          nb;
    exp_aw = '{32'h10, 32'h20, 32'h10};
    nb = 0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req[k].aw_valid = 1'b1; req[k].w_valid = 1'b1; req[k].b_ready = 1'b1;
      req[k].w.data = 32'hD0 + 32'(k); req[k].w.strb = 4'hF;
    end
    req[0].aw.addr = 32'h10;
    req[1].aw.addr = 32'h20;
    dresp.aw_ready = 1'b1;
    dresp.w_ready  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      dresp.b_valid = (sq.size() > 0);
      dresp.b.resp  = (sq.size() == 0) ? 2'b00 : ((sq[0] == 32'h10) ? 2'b01 : 2'b10);
      #1;
      if (dresp.b_valid && dreq.b_ready) begin
        exp_m    = (sq[0] == 32'h10) ? 0 : 1;
        exp_resp = (exp_m == 0) ? 2'b01 : 2'b10;
        checks++; if (resp[exp_m].b_valid !== 1'b1 || resp[exp_m].b.resp !== exp_resp) begin failures++; $display("FAIL rr_b_route m%0d got=%b/%b exp=1/%b", exp_m, resp[exp_m].b_valid, resp[exp_m].b.resp, exp_resp); end
        checks++; if (resp[1-exp_m].b_valid !== 1'b0) begin failures++; $display("FAIL rr_b_other m%0d got=%b exp=0", 1-exp_m, resp[1-exp_m].b_valid); end
        void'(sq.pop_front());
        nb++;
      end
      if (dreq.aw_valid && dresp.aw_ready) begin
        sq.push_back(dreq.aw.addr);
        aw_log.push_back(dreq.aw.addr);
      end
      tick();
    end
    checks++;
    if (aw_log.size() < 3) begin
      failures++; $display("FAIL rr_aw_count got=%0d exp>=3", aw_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (i > 0) checks++;
        if (aw_log[i] !== exp_aw[i]) begin failures++; $display("FAIL rr_aw_order[%0d] got=%h exp=%h", i, aw_log[i], exp_aw[i]); end
      end
    end
    checks++; if (nb < 3) begin failures++; $display("FAIL rr_b_count got=%0d exp>=3", nb); end
    clear_inputs();
  endtask

  task automatic test_w_before_aw();
    int nw;
    nw = 0;
    do_reset();
    dresp.aw_ready = 1'b0;
    dresp.w_ready  = 1'b1;
    req[1].w_valid = 1'b1; req[1].w.data = 32'hCAFE; req[1].w.strb = 4'hF; req[1].b_ready = 1'b1;
    #1;
    checks++; if (dreq.w_valid !== 1'b0 || dut.wr_state_q !== W_IDLE) begin failures++; $display("FAIL wfirst_no_grant got=%b/%b exp=0/0", dreq.w_valid, dut.wr_state_q); end
    tick();
    req[1].aw_valid = 1'b1; req[1].aw.addr = 32'h44;
    #1;
    if (dreq.w_valid && dresp.w_ready) nw++;
    checks++; if (dreq.aw_valid !== 1'b0) begin failures++; $display("FAIL wfirst_latency got=%b exp=0", dreq.aw_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dreq.w_valid && dresp.w_ready) nw++;
      checks++; if (dut.wr_state_q !== W_BUSY || dreq.aw_valid !== 1'b1 || dreq.aw.addr !== 32'h44) begin failures++; $display("FAIL wfirst_busy[%0d] got=%b/%b/%h exp=1/1/00000044", i, dut.wr_state_q, dreq.aw_valid, dreq.aw.addr); end
      checks++; if (resp[1].w_ready !== (i == 0) || resp[0].w_ready !== 1'b0) begin failures++; $display("FAIL wfirst_wready[%0d] got=%b%b exp=%b0", i, resp[1].w_ready, resp[0].w_ready, (i == 0)); end
      tick();
    end
    dresp.aw_ready = 1'b1;
    #1;
    if (dreq.w_valid && dresp.w_ready) nw++;
    checks++; if (resp[1].aw_ready !== 1'b1 || resp[0].aw_ready !== 1'b0) begin failures++; $display("FAIL wfirst_awready got=%b%b exp=10", resp[1].aw_ready, resp[0].aw_ready); end
    tick();
    req[1].aw_valid = 1'b0;
    req[1].w_valid  = 1'b0;
    #1;
    checks++; if (dut.wr_state_q !== W_IDLE) begin failures++; $display("FAIL wfirst_done got=%b exp=0", dut.wr_state_q); end
    checks++; if (nw !== 1) begin failures++; $display("FAIL wfirst_w_count got=%0d exp=1", nw); end
    clear_inputs();
  endtask

  task automatic test_queue_full();
    int nh;
    nh = 0;
    do_reset();
    dresp.aw_ready = 1'b1;
    dresp.w_ready  = 1'b1;
    req[0].aw_valid = 1'b1; req[0].w_valid = 1'b1; req[0].b_ready = 1'b1; req[0].aw.addr = 32'h80;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (dreq.aw_valid && dresp.aw_ready) nh++;
      tick();
    end
    checks++; if (nh !== 2) begin failures++; $display("FAIL full_two_writes got=%0d exp=2", nh); end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (dreq.aw_valid !== 1'b0 || dut.wr_state_q !== W_IDLE) begin failures++; $display("FAIL full_blocked[%0d] got=%b/%b exp=0/0", c, dreq.aw_valid, dut.wr_state_q); end
      tick();
    end
    dresp.b_valid = 1'b1;
    #1;
    checks++; if (resp[0].b_valid !== 1'b1 || dreq.b_ready !== 1'b1) begin failures++; $display("FAIL full_b_release got=%b/%b exp=1/1", resp[0].b_valid, dreq.b_ready); end
    tick();
    dresp.b_valid = 1'b0;
    #1;
    checks++; if (dut.wr_state_q !== W_IDLE || dreq.aw_valid !== 1'b0) begin failures++; $display("FAIL full_after_pop got=%b/%b exp=0/0", dut.wr_state_q, dreq.aw_valid); end
    tick();
    checks++; if (dut.wr_state_q !== W_BUSY || dreq.aw_valid !== 1'b1) begin failures++; $display("FAIL full_regrant got=%b/%b exp=1/1", dut.wr_state_q, dreq.aw_valid); end
    clear_inputs();
  endtask

  task automatic test_read_order();
    do_reset();
    dresp.ar_ready = 1'b1;
    req[0].ar_valid = 1'b1; req[0].ar.addr = 32'h100; req[0].r_ready = 1'b0;
    req[1].ar_valid = 1'b1; req[1].ar.addr = 32'h200; req[1].r_ready = 1'b1;
    tick();
    checks++; if (dreq.ar_valid !== 1'b1 || dreq.ar.addr !== 32'h100) begin failures++; $display("FAIL rd_first_ar got=%b/%h exp=1/00000100", dreq.ar_valid, dreq.ar.addr); end
    tick();
    req[0].ar_valid = 1'b0;
    #1;
    checks++; if (dreq.ar_valid !== 1'b0) begin failures++; $display("FAIL rd_idle_gap got=%b exp=0", dreq.ar_valid); end
    tick();
    checks++; if (dreq.ar_valid !== 1'b1 || dreq.ar.addr !== 32'h200 || resp[1].ar_ready !== 1'b1 || resp[0].ar_ready !== 1'b0) begin failures++; $display("FAIL rd_second_ar got=%b/%h/%b%b exp=1/00000200/10", dreq.ar_valid, dreq.ar.addr, resp[1].ar_ready, resp[0].ar_ready); end
    tick();
    req[1].ar_valid = 1'b0;
    dresp.r_valid = 1'b1; dresp.r.data = 32'hAAAA;
    #1;
    checks++; if (resp[0].r_valid !== 1'b1 || resp[0].r.data !== 32'hAAAA || resp[1].r_valid !== 1'b0) begin failures++; $display("FAIL rd_head_m0 got=%b/%h/%b exp=1/0000aaaa/0", resp[0].r_valid, resp[0].r.data, resp[1].r_valid); end
    checks++; if (dreq.r_ready !== 1'b0) begin failures++; $display("FAIL rd_stall_ready got=%b exp=0", dreq.r_ready); end
    tick();
    req[0].r_ready = 1'b1;
    #1;
    checks++; if (resp[0].r_valid !== 1'b1 || resp[1].r_valid !== 1'b0 || dreq.r_ready !== 1'b1) begin failures++; $display("FAIL rd_pop_m0 got=%b/%b/%b exp=1/0/1", resp[0].r_valid, resp[1].r_valid, dreq.r_ready); end
    tick();
    dresp.r.data = 32'hBBBB;
    #1;
    checks++; if (resp[1].r_valid !== 1'b1 || resp[1].r.data !== 32'hBBBB || resp[0].r_valid !== 1'b0) begin failures++; $display("FAIL rd_head_m1 got=%b/%h/%b exp=1/0000bbbb/0", resp[1].r_valid, resp[1].r.data, resp[0].r_valid); end
    tick();
    dresp.r_valid = 1'b0;
    #1;
    checks++; if (dreq.r_ready !== 1'b0) begin failures++; $display("FAIL rd_empty_ready got=%b exp=0", dreq.r_ready); end
    clear_inputs();
  endtask

  task automatic test_independence();
    do_reset();
    req[0].aw_valid = 1'b1; req[0].w_valid = 1'b1; req[0].aw.addr = 32'h300; req[0].b_ready = 1'b1;
    req[1].ar_valid = 1'b1; req[1].ar.addr = 32'h400; req[1].r_ready = 1'b1;
    dresp.w_ready = 1'b1; dresp.ar_ready = 1'b1; dresp.aw_ready = 1'b0;
    #1;
    checks++; if (dreq.aw_valid !== 1'b0 || dreq.ar_valid !== 1'b0) begin failures++; $display("FAIL ind_latency got=%b%b exp=00", dreq.aw_valid, dreq.ar_valid); end
    tick();
    checks++; if (dreq.aw_valid !== 1'b1 || dreq.aw.addr !== 32'h300 || dreq.ar_valid !== 1'b1 || dreq.ar.addr !== 32'h400) begin failures++; $display("FAIL ind_same_cycle got=%b/%h/%b/%h exp=1/00000300/1/00000400", dreq.aw_valid, dreq.aw.addr, dreq.ar_valid, dreq.ar.addr); end
    checks++; if (resp[1].ar_ready !== 1'b1 || resp[0].ar_ready !== 1'b0 || resp[1].aw_ready !== 1'b0) begin failures++; $display("FAIL ind_readies got=%b%b%b exp=100", resp[1].ar_ready, resp[0].ar_ready, resp[1].aw_ready); end
    tick();
    req[1].ar_valid = 1'b0;
    dresp.aw_ready = 1'b1;
    #1;
    checks++; if (dut.rd_state_q !== R_IDLE || dut.wr_state_q !== W_BUSY) begin failures++; $display("FAIL ind_no_cross_stall got=%b/%b exp=0/1", dut.rd_state_q, dut.wr_state_q); end
    tick();
    req[0].aw_valid = 1'b0; req[0].w_valid = 1'b0;
    #1;
    checks++; if (dut.wr_state_q !== W_IDLE) begin failures++; $display("FAIL ind_write_done got=%b exp=0", dut.wr_state_q); end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_w_before_aw();
    test_queue_full();
    test_read_order();
    test_independence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
